// File: rtl/pipe_pkg.sv
// Shared definitions for the issue arbiter: opcode constants, instruction field
// positions, the bubble encoding and the issue FSM state type.
package pipe_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // Field positions in the 8-bit instruction word {op, rs1, rs2, rd}
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS1_HI = 5;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;

    localparam logic [7:0] NOP_INST_DEF = 8'h00;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        DRAIN = 2'b01,
        IDLE  = 2'b10
    } issue_state_e;

    // True when the instruction will write the register file
    function automatic logic writes_reg(input logic [7:0] inst);
        return inst[OP_HI:OP_LO] != OP_NOP;
    endfunction

endpackage

// File: rtl/pipe_write_tracker.sv
// Shift register of pending register writes (one slot per pipeline stage after
// issue) plus a population count and an early "empty after this edge" flag.
module pipe_write_tracker #(
    parameter int DEPTH = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_in,
    output logic [CNT_W-1:0] count,
    output logic             empty_next
);

    logic [DEPTH-1:0] slots_reg;
    logic [DEPTH-1:0] slots_next;

    assign slots_next[0] = shift_in;

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign slots_next[gi] = slots_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_reg <= '0;
        end else begin
            slots_reg <= slots_next;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CNT_W'(slots_reg[i]);
        end
    end

    // The last slot falls off on this edge, so only the others and the new entry matter
    assign empty_next = (slots_next == '0);

endmodule

// File: rtl/pipe_issue_arbiter.sv
// Round-robin arbiter sharing one pipeline instruction port between two requesters,
// with write tracking and a drain sequence. Optional issue counters: PIPE_ISSUE_STATS_EN.
module pipe_issue_arbiter
    import pipe_pkg::*;
#(
    parameter int             INST_W      = 8,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF,
    parameter int             DRAIN_DEPTH = 3,
    parameter int             STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] req0_inst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [INST_W-1:0] req1_inst,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              drain_req,
    output logic              drain_done,
    output logic [INST_W-1:0] pipe_inst,
    output logic              pipe_grant_id,
    output logic [1:0]        inflight_cnt,
    output logic [STAT_W-1:0] stat0_cnt,
    output logic [STAT_W-1:0] stat1_cnt
);

    issue_state_e      state_reg, state_next;
    logic              rr_ptr_reg;
    logic [INST_W-1:0] pipe_inst_reg;
    logic              grant_id_reg;
    logic              drain_done_reg;

    logic              issue_en;
    logic [1:0]        transfer_vec;
    logic              transfer;
    logic              sel_id;
    logic [INST_W-1:0] sel_inst;
    logic              sel_writes;
    logic              tracker_empty_next;

    always_comb begin
        state_next = state_reg;
        issue_en   = 1'b0;
        case (state_reg)
            RUN: begin
                if (drain_req) begin
                    state_next = DRAIN;
                end else begin
                    issue_en = 1'b1;
                end
            end
            DRAIN: begin
                if (tracker_empty_next) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (!drain_req) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Grant depends only on valids and the pointer, never on instruction contents
    assign req0_ready = !rst && issue_en && req0_valid && (!req1_valid || !rr_ptr_reg);
    assign req1_ready = !rst && issue_en && req1_valid && (!req0_valid ||  rr_ptr_reg);

    assign transfer_vec = {req1_valid && req1_ready, req0_valid && req0_ready};
    assign transfer     = |transfer_vec;
    assign sel_id       = transfer_vec[1];
    assign sel_inst     = sel_id ? req1_inst : req0_inst;
    assign sel_writes   = sel_inst[INST_W-1 -: 2] != OP_NOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= RUN;
            rr_ptr_reg     <= 1'b0;
            pipe_inst_reg  <= NOP_INST;
            grant_id_reg   <= 1'b0;
            drain_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            drain_done_reg <= (state_next == IDLE);
            if (transfer) begin
                rr_ptr_reg    <= ~sel_id;
                pipe_inst_reg <= sel_inst;
                grant_id_reg  <= sel_id;
            end else begin
                pipe_inst_reg <= NOP_INST;
            end
        end
    end

    pipe_write_tracker #(
        .DEPTH (DRAIN_DEPTH),
        .CNT_W (2)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .shift_in   (transfer && sel_writes),
        .count      (inflight_cnt),
        .empty_next (tracker_empty_next)
    );

`ifdef PIPE_ISSUE_STATS_EN
    logic [STAT_W-1:0] stat_reg [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            always_ff @(posedge clk) begin
                if (rst) begin
                    stat_reg[gi] <= '0;
                end else if (transfer_vec[gi] && sel_writes && !(&stat_reg[gi])) begin
                    stat_reg[gi] <= stat_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stat0_cnt = stat_reg[0];
    assign stat1_cnt = stat_reg[1];
`else
    assign stat0_cnt = '0;
    assign stat1_cnt = '0;
`endif

    assign pipe_inst     = pipe_inst_reg;
    assign pipe_grant_id = grant_id_reg;
    assign drain_done    = drain_done_reg;

endmodule

// File: tb/tb_pipe_issue_arbiter.sv
// Directed bench for pipe_issue_arbiter; honours PIPE_ISSUE_STATS_EN when defined.
module tb_pipe_issue_arbiter;

`ifdef PIPE_ISSUE_STATS_EN
    localparam int TB_STAT_W = 2;
    localparam logic [TB_STAT_W-1:0] STAT1_AFTER_B2B = 2'd2;
`else
    localparam int TB_STAT_W = 16;
    localparam logic [TB_STAT_W-1:0] STAT1_AFTER_B2B = 16'd0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           req0_inst, req1_inst;
    logic                 req0_valid, req1_valid;
    logic                 req0_ready, req1_ready;
    logic                 drain_req, drain_done;
    logic [7:0]           pipe_inst;
    logic                 pipe_grant_id;
    logic [1:0]           inflight_cnt;
    logic [TB_STAT_W-1:0] stat0_cnt, stat1_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_issue_arbiter #(
        .INST_W      (8),
        .NOP_INST    (8'h00),
        .DRAIN_DEPTH (3),
        .STAT_W      (TB_STAT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req0_inst     (req0_inst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req1_inst     (req1_inst),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .drain_req     (drain_req),
        .drain_done    (drain_done),
        .pipe_inst     (pipe_inst),
        .pipe_grant_id (pipe_grant_id),
        .inflight_cnt  (inflight_cnt),
        .stat0_cnt     (stat0_cnt),
        .stat1_cnt     (stat1_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_inst  = 8'h00;
        req1_inst  = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1; drain_req = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_inst = 8'h46; req1_inst = 8'h83;
        tick();
        tick();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
        end
        checks++;
        if (pipe_inst !== 8'h00 || pipe_grant_id !== 1'b0 || inflight_cnt !== 2'd0 || drain_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: inst=%h gid=%b cnt=%0d done=%b want 00 0 0 0",
                     pipe_inst, pipe_grant_id, inflight_cnt, drain_done);
        end
        checks++;
        if (stat0_cnt !== '0 || stat1_cnt !== '0) begin
            errors++; $display("FAIL reset_stats: got %0d %0d want 0 0", stat0_cnt, stat1_cnt);
        end
        idle_inputs();
        rst = 1'b0;
        $display("reset: inst=%h cnt=%0d done=%b", pipe_inst, inflight_cnt, drain_done);
    endtask

    task automatic test_back_to_back();
        logic exp_id;
        req0_valid = 1'b1; req0_inst = 8'h41;
        req1_valid = 1'b1; req1_inst = 8'h83;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            #1;
            checks++;
            if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b%b want %b%b", k, req1_ready, req0_ready, exp_id, ~exp_id);
            end
            tick();
            checks++;
            if (pipe_inst !== (exp_id ? 8'h83 : 8'h41) || pipe_grant_id !== exp_id) begin
                errors++;
                $display("FAIL b2b_issue[%0d]: got inst=%h gid=%b want %h %b",
                         k, pipe_inst, pipe_grant_id, exp_id ? 8'h83 : 8'h41, exp_id);
            end
            $display("b2b %0d: inst=%h gid=%b", k, pipe_inst, pipe_grant_id);
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic test_single();
        logic [1:0] exp_cnt [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
        logic [7:0] exp_inst [4] = '{8'h46, 8'h00, 8'h00, 8'h00};
        req0_valid = 1'b1; req0_inst = 8'h46;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready: got %b%b want 01", req1_ready, req0_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            idle_inputs();
            checks++;
            if (pipe_inst !== exp_inst[k] || inflight_cnt !== exp_cnt[k]) begin
                errors++;
                $display("FAIL single[%0d]: got inst=%h cnt=%0d want %h %0d",
                         k, pipe_inst, inflight_cnt, exp_inst[k], exp_cnt[k]);
            end
            $display("single %0d: inst=%h cnt=%0d", k, pipe_inst, inflight_cnt);
        end
    endtask

    task automatic test_nop_issue();
        req1_valid = 1'b1; req1_inst = 8'h00;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (req1_ready !== 1'b1) begin
                errors++; $display("FAIL nop_ready[%0d]: got %b want 1", k, req1_ready);
            end
            tick();
            checks++;
            if (inflight_cnt !== 2'd0 || pipe_grant_id !== 1'b1 || stat1_cnt !== STAT1_AFTER_B2B) begin
                errors++;
                $display("FAIL nop_issue[%0d]: got cnt=%0d gid=%b stat1=%0d want 0 1 %0d",
                         k, inflight_cnt, pipe_grant_id, stat1_cnt, STAT1_AFTER_B2B);
            end
            $display("nop %0d: inst=%h cnt=%0d stat1=%0d", k, pipe_inst, inflight_cnt, stat1_cnt);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_drain();
        req0_valid = 1'b1; req0_inst = 8'hC7;
        tick();
        checks++;
        if (pipe_inst !== 8'hC7 || inflight_cnt !== 2'd1) begin
            errors++; $display("FAIL drain_issue: got inst=%h cnt=%0d want c7 1", pipe_inst, inflight_cnt);
        end
        drain_req = 1'b1;
        req0_inst = 8'h41; req1_valid = 1'b1; req1_inst = 8'h83;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL drain_block: got %b%b want 00", req1_ready, req0_ready);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (drain_done !== (k == 3) || pipe_inst !== 8'h00 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL drain_wait[%0d]: got done=%b inst=%h rdy=%b%b want %b 00 00",
                         k, drain_done, pipe_inst, req1_ready, req0_ready, k == 3);
            end
            $display("drain %0d: done=%b cnt=%0d", k, drain_done, inflight_cnt);
        end
        checks++;
        if (inflight_cnt !== 2'd0) begin
            errors++; $display("FAIL drain_cnt: got %0d want 0", inflight_cnt);
        end
        tick();
        checks++;
        if (drain_done !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL drain_hold: got done=%b rdy=%b%b want 1 00", drain_done, req1_ready, req0_ready);
        end
        drain_req = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL idle_ready: got %b%b want 00", req1_ready, req0_ready);
        end
        tick();
        checks++;
        if (drain_done !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL resume: got done=%b rdy=%b%b want 0 10", drain_done, req1_ready, req0_ready);
        end
        $display("resume: done=%b rdy=%b%b", drain_done, req1_ready, req0_ready);
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_inst = 8'h46;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (inflight_cnt !== 2'd3) begin
            errors++; $display("FAIL mid_full: got cnt=%0d want 3", inflight_cnt);
        end
        rst = 1'b1; req1_valid = 1'b1; req1_inst = 8'h83;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rst_ready: got %b%b want 00", req1_ready, req0_ready);
        end
        tick();
        rst = 1'b0;
        checks++;
        if (pipe_inst !== 8'h00 || inflight_cnt !== 2'd0 || drain_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst: got inst=%h cnt=%0d done=%b want 00 0 0", pipe_inst, inflight_cnt, drain_done);
        end
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL mid_rr: got %b%b want 01", req1_ready, req0_ready);
        end
        $display("mid reset: inst=%h cnt=%0d rdy=%b%b", pipe_inst, inflight_cnt, req1_ready, req0_ready);
        idle_inputs();
        tick();
    endtask

    task automatic test_stats();
`ifdef PIPE_ISSUE_STATS_EN
        logic [1:0] exp_stat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        checks++;
        if (stat0_cnt !== 2'd0 || stat1_cnt !== 2'd0) begin
            errors++; $display("FAIL stat_clear: got %0d %0d want 0 0", stat0_cnt, stat1_cnt);
        end
        req0_valid = 1'b1; req0_inst = 8'h41;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (stat0_cnt !== exp_stat[k] || stat1_cnt !== 2'd0) begin
                errors++;
                $display("FAIL stat_sat[%0d]: got %0d %0d want %0d 0", k, stat0_cnt, stat1_cnt, exp_stat[k]);
            end
            $display("stat %0d: stat0=%0d", k, stat0_cnt);
        end
`else
        req0_valid = 1'b1; req0_inst = 8'h41;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (stat0_cnt !== '0 || stat1_cnt !== '0) begin
            errors++; $display("FAIL stat_tied: got %0d %0d want 0 0", stat0_cnt, stat1_cnt);
        end
        $display("stat tied: stat0=%0d stat1=%0d", stat0_cnt, stat1_cnt);
`endif
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        drain_req = 1'b0;
        test_reset();
        test_back_to_back();
        test_single();
        test_nop_issue();
        test_drain();
        test_reset_mid();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
